// File: rtl/add_pkg.sv
// Shared definitions for the add_arbiter block.
//   ADD_W   : default operand/result width
//   state_t : sequencer states (2-bit encoding)
//   P0/P1   : requester port indices, used as grant values
package add_pkg;

    localparam int ADD_W = 6;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/add_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared add unit.
//   reqN/aN/bN  : requester N request level and operands
//   ackN/resN   : one-cycle completion pulse and result for requester N
//   go          : start pulse to the add unit
//   a_out/b_out : operands presented to the add unit
//   unit_result : add unit result
//   busy        : arbiter is not idle
// Modports: slave = arbiter side, master = requesters/add unit side.
interface add_arbiter_if
    import add_pkg::*;
#(
    parameter int W = ADD_W
) ();

    logic         req0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic         ack0;
    logic [W-1:0] res0;
    logic         req1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         ack1;
    logic [W-1:0] res1;
    logic         go;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic [W-1:0] unit_result;
    logic         busy;

    modport slave (
        input  req0, a0, b0, req1, a1, b1, unit_result,
        output ack0, res0, ack1, res1, go, a_out, b_out, busy
    );

    modport master (
        output req0, a0, b0, req1, a1, b1, unit_result,
        input  ack0, res0, ack1, res1, go, a_out, b_out, busy
    );

endinterface

// File: rtl/add_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker.
//   req0/req1  : request levels
//   last_grant : port granted most recently
//   valid      : at least one request present
//   gnt        : chosen port (meaningful only when valid)
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic gnt
);

    assign valid = req0 | req1;

    // A tie goes to the port that did not win last time; otherwise the lone
    // requester wins (req1 alone -> 1, req0 alone -> 0).
    assign gnt = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter/sequencer in front of one shared add unit.
//   CLK   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : requester handshakes, add unit operands/go/result, busy
// Flow: IDLE picks a requester and latches its operands, ISSUE pulses go,
// WAIT counts LAT cycles, the last WAIT cycle captures unit_result, DONE
// pulses the granted port's ack.
module add_arbiter
    import add_pkg::*;
#(
    parameter int W   = ADD_W,
    parameter int LAT = 3
) (
    input logic          CLK,
    input logic          reset,
    add_arbiter_if.slave bus
);

    // Counter runs LAT-1 .. 0 across WAIT, so WAIT lasts exactly LAT cycles
    // and the capture cycle lines up with go+LAT.
    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_t       state;
    state_t       state_nxt;
    logic         gnt;
    logic         last_grant;
    logic         pick_vld;
    logic         pick_gnt;
    logic [3:0]   cnt;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] res0_q;
    logic [W-1:0] res1_q;

    rr_pick2 u_pick (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_grant (last_grant),
        .valid      (pick_vld),
        .gnt        (pick_gnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            gnt        <= P0;
            last_grant <= P1;   // port 0 wins the first tie
            cnt        <= 4'd0;
            a_q        <= '0;
            b_q        <= '0;
            res0_q     <= '0;
            res1_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt        <= pick_gnt;
                        last_grant <= pick_gnt;
                        a_q        <= (pick_gnt == P1) ? bus.a1 : bus.a0;
                        b_q        <= (pick_gnt == P1) ? bus.b1 : bus.b0;
                    end
                end
                ISSUE: cnt <= CNT_LOAD;
                WAIT: begin
                    if (cnt == 4'd0) begin
                        if (gnt == P1) res1_q <= bus.unit_result;
                        else           res0_q <= bus.unit_result;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the async-reset state register, so they
    // fall the instant reset asserts and cannot pulse while it is held.
    assign bus.go    = (state == ISSUE);
    assign bus.busy  = (state != IDLE);
    assign bus.ack0  = (state == DONE) && (gnt == P0);
    assign bus.ack1  = (state == DONE) && (gnt == P1);
    assign bus.a_out = a_q;
    assign bus.b_out = b_q;
    assign bus.res0  = res0_q;
    assign bus.res1  = res1_q;

endmodule
